snoop_bus_arbiter: RTL and testbench
====================================

# snoop_bus_arbiter

Round-robin arbiter and transaction sequencer for the shared snooping bus used by the three MSI cache processors (ids 0..2). It grants the bus to one requester at a time and broadcasts its coherence message and block address to the other caches. It then opens a snoop window, sequences victim and snoop write-backs to memory, and performs the memory read for read misses. It sits between the processors' bus-request side and the shared memory port.

## Interface
- `SNOOP_CYC`, default 2: snoop window length in cycles (≥1).
- `MEM_LAT`, default 4: memory read duration in cycles (≥1).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  3  bit i = processor i requests the bus; held until its `done`.
- `msg`  in  6  msg[2i+1:2i] = message of processor i: 00 invalidar, 01 readMiss, 10 writeMiss, 11 semMensagem.
- `addr`  in  9  addr[3i+2:3i] = 3-bit block tag of processor i.
- `victim_wb`  in  3  bit i = granted processor i must write back its victim block.
- `snoop_wb`  in  3  bit i = receiver i holds the block Modified and must write back.
- `grant`  out  3  one-hot owner; 000 when idle.
- `bus_valid`  out  1  one-cycle broadcast strobe.
- `bus_msg`  out  2  latched message of the owner.
- `bus_addr`  out  3  latched tag of the owner.
- `wb_strobe`  out  1  one-cycle write-back command to memory.
- `wb_src`  out  2  index of the processor whose write-back is being executed.
- `mem_read`  out  1  high during the memory read.
- `mem_addr`  out  3  equals `bus_addr` while `mem_read` is high, else 0.
- `done`  out  3  one-hot, one-cycle completion pulse to the owner.

## Operation
- States: IDLE, BCAST, SNOOP, WB_VICT, WB_SNOOP, MEM, DONE.
- IDLE: if `req` is nonzero, pick the first set bit starting at pointer `rr` (wrapping 0→1→2→0). Latch owner, `msg` slice and `addr` slice, latch `victim_wb[owner]`, then go to BCAST. Set `rr` = (owner+1) mod 3.
- BCAST: `bus_valid`=1. If msg=11, go to DONE; otherwise go to SNOOP.
- SNOOP: lasts SNOOP_CYC cycles. Accumulates `snoop_wb & ~grant` into a sticky OR, latching the lowest-index receiver. On exit, go to the first applicable of WB_VICT, WB_SNOOP, MEM, DONE.
- WB_VICT: entered only when the latched victim flag is set and msg ∈ {01,10}. `wb_strobe`=1 for one cycle, `wb_src`=owner.
- WB_SNOOP: entered only when a snoop write-back was captured and msg ∈ {01,10}. `wb_strobe`=1 for one cycle, `wb_src`=receiver. Write-backs requested during invalidar (00) are ignored.
- MEM: entered only for msg=01. `mem_read`=1 for MEM_LAT cycles.
- writeMiss performs no memory read; the owner writes its own data.
- DONE: `done[owner]`=1 for one cycle, `grant` still held. Then go to IDLE and clear `grant`.
- Deasserting `req` mid-transaction is ignored; the transaction always completes.
- `req` bits of non-owners are ignored until IDLE.

## Timing
- Reset, asynchronous: state IDLE, `rr`=0, and every output 0 (`grant`, `bus_valid`, `bus_msg`, `bus_addr`, `wb_strobe`, `wb_src`, `mem_read`, `mem_addr`, `done`). Reset mid-transaction aborts it with no `done`.
- Outputs are registered. If `req` is sampled at edge t, `grant` and `bus_valid` appear after edge t+1.
- Total cycles from grant to `done`:
  - msg=11: 2 cycles.
  - msg=00: 2+SNOOP_CYC cycles.
  - msg=01: 2+SNOOP_CYC+vict+snp+MEM_LAT cycles.
  - msg=10: 2+SNOOP_CYC+vict+snp cycles.
  - vict and snp are each 0 or 1.
- There is at least one IDLE cycle between consecutive grants.
- `snoop_wb` is sampled only in SNOOP. The owner's own bit is always masked.
- Simultaneous snoop write-backs from two receivers: only the lowest index is serviced. This is legal because at most one cache can hold the block Modified.

## Structure
- Shared package `snoop_pkg` holds:
  - message encodings (invalidar, msgReadMiss, msgWriteMiss, semMensagem);
  - MSI state encodings (invalido 00, modificado 01, compartilhado 10);
  - the state enum;
  - NPROC=3.
- One sub-module, `rr_pick3`: combinational round-robin selector taking `req` and `rr` and producing a one-hot winner plus index.

## Test plan
- After reset, `req`=001, msg0=01, addr0=011, no write-backs → `grant`=001, `bus_msg`=01, `bus_addr`=011. `mem_read` is high 4 cycles with `mem_addr`=011, and `done`=001 arrives 8 cycles after grant.
- `req`=111 held continuously across transactions → grants in order 001, 010, 100, 001.
- P2 readMiss addr=010 with `victim_wb`[2]=1 and `snoop_wb`=001 during SNOOP → `wb_strobe` first with `wb_src`=2, then with `wb_src`=0, then MEM.
- P1 invalidar with `snoop_wb`=011 asserted → no `wb_strobe` and no `mem_read`; `done`=010 arrives 4 cycles after grant.
- P0 writeMiss with `snoop_wb`=100 → one `wb_strobe` with `wb_src`=2, no `mem_read`.
- `reset` pulsed during MEM → all outputs 0 immediately. The next `req`=010 is granted to P1 because `rr` is back at 0 and only P1 requests.

Source files
------------

// File: rtl/snoop_pkg.sv
// Shared definitions for the three-processor MSI snooping bus: message and
// cache-state encodings, arbiter FSM states and a lowest-index helper.
package snoop_pkg;

  localparam int NPROC = 3;

  typedef enum logic [1:0] {
    INVALIDAR      = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    SEM_MENSAGEM   = 2'b11
  } msg_t;

  typedef enum logic [1:0] {
    INVALIDO      = 2'b00,
    MODIFICADO    = 2'b01,
    COMPARTILHADO = 2'b10
  } msi_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCAST,
    ST_SNOOP,
    ST_WB_VICT,
    ST_WB_SNOOP,
    ST_MEM,
    ST_DONE
  } state_t;

  function automatic logic [1:0] lowest_idx3(input logic [NPROC-1:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Processor-side request/broadcast signals plus the memory command port of
// the snooping bus arbiter.
interface snoop_bus_arbiter_if;
  import snoop_pkg::*;

  logic [NPROC-1:0]   req;
  logic [2*NPROC-1:0] msg;
  logic [3*NPROC-1:0] addr;
  logic [NPROC-1:0]   victim_wb;
  logic [NPROC-1:0]   snoop_wb;

  logic [NPROC-1:0]   grant;
  logic               bus_valid;
  logic [1:0]         bus_msg;
  logic [2:0]         bus_addr;
  logic               wb_strobe;
  logic [1:0]         wb_src;
  logic               mem_read;
  logic [2:0]         mem_addr;
  logic [NPROC-1:0]   done;

  modport master (
    input  req, msg, addr, victim_wb, snoop_wb,
    output grant, bus_valid, bus_msg, bus_addr, wb_strobe, wb_src,
           mem_read, mem_addr, done
  );

  modport slave (
    output req, msg, addr, victim_wb, snoop_wb,
    input  grant, bus_valid, bus_msg, bus_addr, wb_strobe, wb_src,
           mem_read, mem_addr, done
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_pick3.sv
// Combinational round-robin selector: first requester at or after rr_i,
// wrapping 0->1->2->0.
module rr_pick3
  import snoop_pkg::*;
(
  input  logic [NPROC-1:0] req_i,
  input  logic [1:0]       rr_i,
  output logic [NPROC-1:0] win_oh_o,
  output logic [1:0]       win_idx_o,
  output logic             any_o
);

  logic [1:0]       cand [NPROC];
  logic [NPROC-1:0] hit;

  // cand[gi] is the processor examined gi places after the pointer
  for (genvar gi = 0; gi < NPROC; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum      = {1'b0, rr_i} + 3'(gi);
    assign cand[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign hit[gi]  = req_i[cand[gi]];
  end

  assign win_idx_o = hit[0] ? cand[0] : (hit[1] ? cand[1] : cand[2]);
  assign any_o     = |req_i;
  assign win_oh_o  = any_o ? (3'b001 << win_idx_o) : '0;

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner selection and transaction sequencing for the snooping
// bus: broadcast, snoop window, victim/snoop write-backs, memory read, done.
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int SNOOP_CYC = 2,
  parameter int MEM_LAT   = 4
) (
  input logic                 clock,
  input logic                 reset,
  snoop_bus_arbiter_if.master bus
);

  localparam int CNT_W = 8;

  state_t           state_q;
  logic [1:0]       rr_q;
  logic [1:0]       own_idx_q;
  logic [NPROC-1:0] own_oh_q;
  msg_t             msg_q;
  logic [2:0]       addr_q;
  logic             vict_q;
  logic [NPROC-1:0] snp_acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NPROC-1:0] grant_q;
  logic             bus_valid_q;
  logic [1:0]       bus_msg_q;
  logic [2:0]       bus_addr_q;
  logic             wb_strobe_q;
  logic [1:0]       wb_src_q;
  logic             mem_read_q;
  logic [NPROC-1:0] done_q;

  logic [NPROC-1:0] pick_oh;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic [1:0]       pick_msg;
  logic [2:0]       pick_addr;
  logic [NPROC-1:0] snp_acc_d;
  logic             rw_txn;
  state_t           after_snoop, after_vict, after_snp;

  rr_pick3 u_pick (
    .req_i     (bus.req),
    .rr_i      (rr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    pick_msg  = bus.msg[1:0];
    pick_addr = bus.addr[2:0];
    case (pick_idx)
      2'd1: begin pick_msg = bus.msg[3:2]; pick_addr = bus.addr[5:3]; end
      2'd2: begin pick_msg = bus.msg[5:4]; pick_addr = bus.addr[8:6]; end
      default: ;
    endcase
  end

  // Only read/write misses move data; invalidations drop write-back requests
  assign rw_txn    = (msg_q == MSG_READ_MISS) || (msg_q == MSG_WRITE_MISS);
  assign snp_acc_d = snp_acc_q | (bus.snoop_wb & ~own_oh_q);

  always_comb begin
    after_snp   = (msg_q == MSG_READ_MISS) ? ST_MEM : ST_DONE;
    after_vict  = (rw_txn && (|snp_acc_q)) ? ST_WB_SNOOP : after_snp;
    after_snoop = (rw_txn && vict_q) ? ST_WB_VICT :
                  ((rw_txn && (|snp_acc_d)) ? ST_WB_SNOOP : after_snp);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      own_idx_q   <= '0;
      own_oh_q    <= '0;
      msg_q       <= INVALIDAR;
      addr_q      <= '0;
      vict_q      <= 1'b0;
      snp_acc_q   <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_msg_q   <= '0;
      bus_addr_q  <= '0;
      wb_strobe_q <= 1'b0;
      wb_src_q    <= '0;
      mem_read_q  <= 1'b0;
      done_q      <= '0;
    end else begin
      bus_valid_q <= 1'b0;
      wb_strobe_q <= 1'b0;
      wb_src_q    <= '0;
      mem_read_q  <= 1'b0;
      done_q      <= '0;
      case (state_q)
        ST_IDLE: begin
          grant_q <= '0;
          if (pick_any) begin
            own_idx_q <= pick_idx;
            own_oh_q  <= pick_oh;
            msg_q     <= msg_t'(pick_msg);
            addr_q    <= pick_addr;
            vict_q    <= bus.victim_wb[pick_idx];
            snp_acc_q <= '0;
            rr_q      <= (pick_idx == 2'd2) ? 2'd0 : 2'(pick_idx + 2'd1);
            state_q   <= ST_BCAST;
          end
        end
        ST_BCAST: begin
          grant_q     <= own_oh_q;
          bus_valid_q <= 1'b1;
          bus_msg_q   <= msg_q;
          bus_addr_q  <= addr_q;
          cnt_q       <= CNT_W'(SNOOP_CYC - 1);
          state_q     <= (msg_q == SEM_MENSAGEM) ? ST_DONE : ST_SNOOP;
        end
        ST_SNOOP: begin
          snp_acc_q <= snp_acc_d;
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= after_snoop;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WB_VICT: begin
          wb_strobe_q <= 1'b1;
          wb_src_q    <= own_idx_q;
          state_q     <= after_vict;
        end
        ST_WB_SNOOP: begin
          wb_strobe_q <= 1'b1;
          wb_src_q    <= lowest_idx3(snp_acc_q);
          state_q     <= after_snp;
        end
        ST_MEM: begin
          mem_read_q <= 1'b1;
          if (cnt_q == '0) state_q <= ST_DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_DONE: begin
          done_q  <= own_oh_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_msg   = bus_msg_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.wb_strobe = wb_strobe_q;
  assign bus.wb_src    = wb_src_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = mem_read_q ? bus_addr_q : 3'b000;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed and randomized transactions on the snooping bus arbiter, each
// compared cycle by cycle against a transaction-level expectation.
module tb_snoop_bus_arbiter;
  import snoop_pkg::*;

  localparam int SNOOP_CYC = 2;
  localparam int MEM_LAT   = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   rr_m     = 0;
  int   txn_no   = 0;

  snoop_bus_arbiter_if bus ();

  snoop_bus_arbiter #(.SNOOP_CYC(SNOOP_CYC), .MEM_LAT(MEM_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] outs_now();
    return {13'b0, bus.grant, bus.bus_valid, bus.bus_msg, bus.bus_addr,
            bus.wb_strobe, bus.wb_src, bus.mem_read, bus.mem_addr, bus.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clock);
    check("reset_outputs", outs_now(), 32'd0);
    reset = 1'b0;
    rr_m  = 0;
  endtask

  // Transaction-level model: owner from the rotating pointer, then the
  // phase layout broadcast / snoop window / write-backs / memory read / done.
  task automatic run_txn(input bit keep_req, input int exp_wait);
    int p, m, a, rw, v, s, recv, mm, dur, rq, sm, wait_n, wb_at;
    logic [2:0]  g_oh;
    logic [31:0] e, o;
    logic        is_wb, is_mem, is_done;
    logic [1:0]  src;
    rq = int'(bus.req);
    p = -1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (rr_m + k) % 3;
      if (p < 0 && ((rq >> c) & 1) == 1) p = c;
    end
    if (p < 0) p = 0;
    m    = (int'(bus.msg) >> (2 * p)) & 3;
    a    = (int'(bus.addr) >> (3 * p)) & 7;
    rw   = (m == 1 || m == 2) ? 1 : 0;
    v    = (rw == 1 && ((int'(bus.victim_wb) >> p) & 1) == 1) ? 1 : 0;
    sm   = int'(bus.snoop_wb) & ~(1 << p) & 7;
    s    = (rw == 1 && sm != 0) ? 1 : 0;
    recv = ((sm & 1) != 0) ? 0 : (((sm & 2) != 0) ? 1 : 2);
    mm   = (m == 1) ? MEM_LAT : 0;
    dur  = (m == 3) ? 2 : 2 + SNOOP_CYC + v + s + mm;
    g_oh = 3'(1 << p);
    txn_no++;

    wait_n = 0;
    while (bus.grant == '0 && wait_n < 10) begin
      @(negedge clock);
      wait_n++;
    end
    if (bus.grant == '0) begin
      checks++;
      failures++;
      $display("FAIL grant_wait txn%0d: no grant within 10 cycles, expected %b", txn_no, g_oh);
      return;
    end
    check($sformatf("txn%0d grant_latency", txn_no), 32'(wait_n), 32'(exp_wait));

    wb_at = 1 + SNOOP_CYC;
    for (int c = 0; c < dur; c++) begin
      is_wb   = ((v == 1 && c == wb_at) || (s == 1 && c == wb_at + v)) ? 1'b1 : 1'b0;
      src     = (v == 1 && c == wb_at) ? 2'(p) : 2'(recv);
      is_mem  = (c >= wb_at + v + s && c < wb_at + v + s + mm) ? 1'b1 : 1'b0;
      is_done = (c == dur - 1) ? 1'b1 : 1'b0;
      e = {13'b0, g_oh, (c == 0) ? 1'b1 : 1'b0, 2'(m), 3'(a), is_wb,
           is_wb ? src : 2'b00, is_mem, is_mem ? 3'(a) : 3'b000,
           is_done ? g_oh : 3'b000};
      o = {13'b0, bus.grant, bus.bus_valid, bus.bus_msg, bus.bus_addr, bus.wb_strobe,
           bus.wb_strobe ? bus.wb_src : 2'b00, bus.mem_read, bus.mem_addr, bus.done};
      check($sformatf("txn%0d cyc%0d", txn_no, c), o, e);
      if (c == dur - 1 && !keep_req) bus.req = '0;
      @(negedge clock);
    end
    check($sformatf("txn%0d idle_gap", txn_no), {26'b0, bus.grant, bus.done}, 32'd0);
    rr_m = (p + 1) % 3;
    $display("txn %0d owner=%0d msg=%0d addr=%0d vict=%0d snp=%0d recv=%0d cycles=%0d",
             txn_no, p, m, a, v, s, recv, dur);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.req       = '0;
    bus.msg       = '0;
    bus.addr      = '0;
    bus.victim_wb = '0;
    bus.snoop_wb  = '0;
    @(negedge clock);
    check("reset_state", outs_now(), 32'd0);
    reset = 1'b0;

    // P0 readMiss, tag 011, no write-backs
    bus.msg = 6'b11_11_01; bus.addr = 9'b000_000_011;
    bus.victim_wb = '0; bus.snoop_wb = '0; bus.req = 3'b001;
    run_txn(1'b0, 2);

    // All three requesting continuously: 001, 010, 100, 001
    apply_reset();
    bus.msg = 6'b11_00_10; bus.addr = 9'b101_110_001;
    bus.victim_wb = '0; bus.snoop_wb = '0; bus.req = 3'b111;
    run_txn(1'b1, 2);
    run_txn(1'b1, 1);
    run_txn(1'b1, 1);
    run_txn(1'b0, 1);

    // P2 readMiss with victim and snoop write-back from P0
    bus.msg = 6'b01_11_11; bus.addr = 9'b010_000_000;
    bus.victim_wb = 3'b100; bus.snoop_wb = 3'b001; bus.req = 3'b100;
    run_txn(1'b0, 2);

    // P1 invalidar: write-back requests ignored
    bus.msg = 6'b11_00_11; bus.addr = 9'b000_111_000;
    bus.victim_wb = 3'b010; bus.snoop_wb = 3'b011; bus.req = 3'b010;
    run_txn(1'b0, 2);

    // P0 writeMiss with snoop write-back from P2
    bus.msg = 6'b11_11_10; bus.addr = 9'b000_000_110;
    bus.victim_wb = '0; bus.snoop_wb = 3'b100; bus.req = 3'b001;
    run_txn(1'b0, 2);

    for (int i = 0; i < 40; i++) begin
      bus.msg       = 6'($urandom);
      bus.addr      = 9'($urandom);
      bus.victim_wb = 3'($urandom);
      bus.snoop_wb  = 3'($urandom);
      bus.req       = 3'($urandom_range(1, 7));
      run_txn(1'b0, 2);
    end

    // Reset pulsed during the memory read aborts the transaction
    apply_reset();
    bus.msg = 6'b11_11_01; bus.addr = 9'b000_000_101;
    bus.victim_wb = '0; bus.snoop_wb = '0; bus.req = 3'b001;
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("mem_read_before_reset", {31'b0, bus.mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_mem", outs_now(), 32'd0);
    bus.req = '0;
    @(negedge clock);
    check("reset_held", outs_now(), 32'd0);
    rr_m = 0;
    bus.msg = 6'b11_00_01; bus.addr = 9'b000_011_000;
    bus.req = 3'b010;
    reset   = 1'b0;
    run_txn(1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
